writeback_arbiter: RTL and testbench

//   Collects integer results from NUM_SRC execution units (ALU, MUL/DIV, LSU, ...), buffers each in a
//   per-source FIFO and emits at most one architectural register write per cycle on o_int_reg_wb.
//   o_int_reg_wb is the single write port for the integer register file. It is also the release

---
 rtl/writeback_arbiter_pkg.sv | 25 ++
 rtl/writeback_arbiter_wb_fifo.sv | 44 ++++
 rtl/writeback_arbiter.sv | 118 +++++++++++
 tb/tb_writeback_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared types and defaults for the integer writeback arbiter.
// int_arch_reg_wb_t is also consumed by the register file and the issue scoreboard.
package writeback_arbiter_pkg;

  localparam int WB_NUM_SRC    = 3;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int REG_IDX_W     = 5;
  localparam int XLEN          = 32;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } int_arch_reg_wb_t;

  typedef struct packed {
    logic [REG_IDX_W-1:0] idx;
    logic [XLEN-1:0]      data;
  } wb_src_t;

  function automatic int rr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// Single-source result FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable without a counter.
module writeback_arbiter_wb_fifo
  import writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    push,
  input  logic    pop,
  input  logic    flush,
  input  wb_src_t din,
  output wb_src_t dout,
  output logic    empty,
  output logic    full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  wb_src_t     mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges per-unit integer results into the single RF write port, which also
// releases issue-scoreboard entries; round-robin across sources, FIFO within one.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int NUM_SRC    = WB_NUM_SRC,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_flush,
  input  logic [NUM_SRC-1:0]                  i_src_valid,
  input  logic [NUM_SRC-1:0][REG_IDX_W-1:0]   i_src_idx,
  input  logic [NUM_SRC-1:0][XLEN-1:0]        i_src_data,
  output logic [NUM_SRC-1:0]                  o_src_ready,
  output int_arch_reg_wb_t                    o_int_reg_wb,
  output logic                                o_busy
);

  localparam int PW = rr_width(NUM_SRC);

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] empty;
  logic [NUM_SRC-1:0] full;
  wb_src_t [NUM_SRC-1:0] head;

  logic          gnt_vld;
  logic [PW-1:0] gnt_src;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_nxt;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    wb_src_t din;
    assign din     = {i_src_idx[s], i_src_data[s]};
    // Writes to x0 are acknowledged but never stored.
    assign push[s] = i_src_valid[s] & ~full[s] & (i_src_idx[s] != '0);
    assign pop[s]  = gnt_vld & (gnt_src == PW'(s));

    writeback_arbiter_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (push[s]),
      .pop     (pop[s]),
      .flush   (i_flush),
      .din     (din),
      .dout    (head[s]),
      .empty   (empty[s]),
      .full    (full[s])
    );
  end

  assign o_src_ready = ~full;

  // First non-empty source at or above rr_ptr, else wrap to the lowest one below it.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_src = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (!gnt_vld && !empty[s] && (PW'(s) >= rr_ptr)) begin
        gnt_vld = 1'b1;
        gnt_src = PW'(s);
      end
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      if (!gnt_vld && !empty[s] && (PW'(s) < rr_ptr)) begin
        gnt_vld = 1'b1;
        gnt_src = PW'(s);
      end
    end
  end

  assign rr_nxt = (gnt_src == PW'(NUM_SRC-1)) ? '0 : gnt_src + PW'(1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      o_int_reg_wb <= '0;
      rr_ptr       <= '0;
    end else if (gnt_vld) begin
      o_int_reg_wb <= {1'b1, head[gnt_src].idx, head[gnt_src].data};
      rr_ptr       <= rr_nxt;
    end else begin
      o_int_reg_wb <= '0;
    end
  end

  assign o_busy = ~(&empty) | o_int_reg_wb.valid;

`ifndef SYNTHESIS
  // The issue stage blocks WAW, so an idx may be in flight at most once.
  logic [31:0] inflight;
  logic [31:0] pushed_mask;
  logic [31:0] release_mask;
  logic        dup_push;

  always_comb begin
    pushed_mask = '0;
    dup_push    = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push[s]) begin
        if (inflight[i_src_idx[s]] || pushed_mask[i_src_idx[s]]) dup_push = 1'b1;
        pushed_mask[i_src_idx[s]] = 1'b1;
      end
    end
    release_mask = o_int_reg_wb.valid ? (32'd1 << o_int_reg_wb.idx) : 32'd0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      inflight <= '0;
    end else begin
      assert (!dup_push) else $error("writeback idx pushed while already in flight");
      inflight <= (inflight & ~release_mask) | pushed_mask;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed and randomized checks of writeback_arbiter against a queue-based
// reference model of per-source FIFOs and round-robin selection.
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  localparam int NS    = 3;
  localparam int DEPTH = 2;

  typedef logic [36:0] ent_t;

  logic                     clk;
  logic                     rst_n;
  logic                     flush;
  logic [NS-1:0]            src_valid;
  logic [NS-1:0][4:0]       src_idx;
  logic [NS-1:0][31:0]      src_data;
  logic [NS-1:0]            ready;
  int_arch_reg_wb_t         wb;
  logic                     busy;

  writeback_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_src_valid  (src_valid),
    .i_src_idx    (src_idx),
    .i_src_data   (src_data),
    .o_src_ready  (ready),
    .o_int_reg_wb (wb),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  ent_t       mq [NS][$];
  int         rr_m;
  logic       exp_v;
  logic [4:0] exp_i;
  logic [31:0] exp_d;
  bit         inuse [32];
  bit         acc [NS];
  logic [4:0] emitted [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_edge();
    int   g;
    logic pv;
    logic [4:0] pidx;
    ent_t e;
    pv   = exp_v;
    pidx = exp_i;
    for (int s = 0; s < NS; s++) acc[s] = 1'b0;
    if (!rst_n || flush) begin
      for (int s = 0; s < NS; s++) mq[s].delete();
      exp_v = 1'b0;
      exp_i = '0;
      exp_d = '0;
      rr_m  = 0;
      for (int i = 0; i < 32; i++) inuse[i] = 1'b0;
      return;
    end
    g = -1;
    for (int k = 0; k < NS; k++) begin
      int s;
      s = (rr_m + k) % NS;
      if (g < 0 && mq[s].size() > 0) g = s;
    end
    for (int s = 0; s < NS; s++) acc[s] = src_valid[s] && (mq[s].size() < DEPTH);
    if (g >= 0) begin
      e = mq[g].pop_front();
      exp_v = 1'b1;
      {exp_i, exp_d} = e;
      rr_m = (g + 1) % NS;
    end else begin
      exp_v = 1'b0;
    end
    if (pv) inuse[pidx] = 1'b0;
    for (int s = 0; s < NS; s++) begin
      if (acc[s] && src_idx[s] != 5'd0) begin
        mq[s].push_back({src_idx[s], src_data[s]});
        inuse[src_idx[s]] = 1'b1;
      end
    end
  endfunction

  task automatic check_outputs(input string tag);
    logic [NS-1:0] er;
    logic eb;
    eb = exp_v;
    for (int s = 0; s < NS; s++) begin
      er[s] = (mq[s].size() < DEPTH);
      if (mq[s].size() > 0) eb = 1'b1;
    end
    chk({tag, ".rdy"}, 64'(ready), 64'(er));
    chk({tag, ".vld"}, 64'(wb.valid), 64'(exp_v));
    if (exp_v) chk({tag, ".wb"}, 64'({wb.idx, wb.data}), 64'({exp_i, exp_d}));
    chk({tag, ".busy"}, 64'(busy), 64'(eb));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
    if (wb.valid) emitted.push_back(wb.idx);
  endtask

  task automatic idle_inputs();
    src_valid = '0;
    src_idx   = '0;
    src_data  = '0;
    flush     = 1'b0;
  endtask

  initial begin
    int n0, n1, n2, cnt;
    bit saw_drop;
    bit taken [32];
    logic [4:0] x;
    logic [4:0] src1_seen [$];

    rst_n = 1'b0;
    idle_inputs();
    rr_m = 0; exp_v = 0; exp_i = 0; exp_d = 0;

    // Reset and idle
    step("rst");
    step("rst");
    rst_n = 1'b1;
    step("idle");
    chk("rst_wb", 64'(wb), 64'(0));
    chk("rst_ready", 64'(ready), 64'(3'b111));
    chk("rst_busy", 64'(busy), 64'(0));

    // Single ALU result, one-cycle latency
    src_valid = 3'b001; src_idx[0] = 5'd5; src_data[0] = 32'hDEAD_BEEF;
    step("alu_push");
    chk("alu_lat0", 64'(wb.valid), 64'(0));
    idle_inputs();
    step("alu_out");
    chk("alu_wb", 64'(wb), 64'({1'b1, 5'd5, 32'hDEAD_BEEF}));
    step("alu_gone");
    chk("alu_once", 64'(wb.valid), 64'(0));

    // Three-way contention from rr_ptr 0
    flush = 1'b1;
    step("tw_flush");
    flush = 1'b0;
    src_valid = 3'b111;
    src_idx[0] = 5'd1; src_idx[1] = 5'd2; src_idx[2] = 5'd3;
    src_data[0] = 32'h11; src_data[1] = 32'h22; src_data[2] = 32'h33;
    step("tw_push");
    idle_inputs();
    step("tw1");
    chk("tw_first", 64'({wb.valid, wb.idx}), 64'({1'b1, 5'd1}));
    step("tw2");
    chk("tw_second", 64'({wb.valid, wb.idx}), 64'({1'b1, 5'd2}));
    step("tw3");
    chk("tw_third", 64'({wb.valid, wb.idx}), 64'({1'b1, 5'd3}));
    step("tw_end");
    chk("tw_idle", 64'(wb.valid), 64'(0));
    // rr_ptr wrapped to 0: src0 must win over src1
    src_valid = 3'b011;
    src_idx[0] = 5'd7; src_idx[1] = 5'd6;
    step("rr_push");
    idle_inputs();
    step("rr1");
    chk("rr_wrap_first", 64'(wb.idx), 64'(5'd7));
    step("rr2");
    chk("rr_wrap_second", 64'(wb.idx), 64'(5'd6));
    step("rr_end");

    // Back-pressure on src1 with all sources busy
    emitted.delete();
    n0 = 16; n1 = 8; n2 = 24;
    saw_drop = 1'b0;
    for (int c = 0; c < 60 && (n0 < 20 || n1 < 12 || n2 < 28); c++) begin
      if (!ready[1]) saw_drop = 1'b1;
      src_valid = {n2 < 28, n1 < 12, n0 < 20};
      src_idx[0] = 5'(n0); src_idx[1] = 5'(n1); src_idx[2] = 5'(n2);
      for (int s = 0; s < NS; s++) src_data[s] = $urandom;
      step("bp");
      if (acc[0]) n0++;
      if (acc[1]) n1++;
      if (acc[2]) n2++;
    end
    idle_inputs();
    for (int c = 0; c < 10; c++) step("bp_drain");
    chk("bp_ready_drop", 64'(saw_drop), 64'(1));
    chk("bp_total", 64'(emitted.size()), 64'(12));
    foreach (emitted[i]) if (emitted[i] >= 5'd8 && emitted[i] <= 5'd11) src1_seen.push_back(emitted[i]);
    chk("bp_src1_cnt", 64'(src1_seen.size()), 64'(4));
    foreach (src1_seen[i]) chk("bp_src1_order", 64'(src1_seen[i]), 64'(8 + i));

    // x0 write: accepted, never emitted
    emitted.delete();
    src_valid = 3'b100; src_idx[2] = 5'd0; src_data[2] = 32'd7;
    step("x0_push");
    chk("x0_ready", 64'(ready[2]), 64'(1));
    idle_inputs();
    for (int c = 0; c < 4; c++) step("x0_wait");
    chk("x0_never", 64'(emitted.size()), 64'(0));
    chk("x0_busy", 64'(busy), 64'(0));

    // Flush with results queued and one arriving
    src_valid = 3'b011; src_idx[0] = 5'd12; src_idx[1] = 5'd14;
    step("fl_q1");
    src_valid = 3'b001; src_idx[0] = 5'd13;
    step("fl_q2");
    src_valid = 3'b100; src_idx[2] = 5'd15; flush = 1'b1;
    step("fl");
    idle_inputs();
    chk("fl_vld", 64'(wb.valid), 64'(0));
    chk("fl_busy", 64'(busy), 64'(0));
    chk("fl_ready", 64'(ready), 64'(3'b111));
    emitted.delete();
    for (int c = 0; c < 5; c++) step("fl_after");
    cnt = 0;
    foreach (emitted[i]) if (emitted[i] >= 5'd12 && emitted[i] <= 5'd15) cnt++;
    chk("fl_no_stale", 64'(cnt), 64'(0));

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 32; i++) taken[i] = 1'b0;
      rst_n = ($urandom_range(0, 99) != 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int s = 0; s < NS; s++) begin
        src_valid[s] = 1'($urandom_range(0, 1));
        src_data[s]  = $urandom;
        if ($urandom_range(0, 9) == 0) begin
          src_idx[s] = 5'd0;
        end else begin
          do x = 5'($urandom_range(1, 31)); while (inuse[x] || taken[x]);
          taken[x] = 1'b1;
          src_idx[s] = x;
        end
      end
      step("rnd");
    end
    rst_n = 1'b1;
    idle_inputs();
    for (int c = 0; c < 10; c++) step("rnd_drain");
    chk("end_busy", 64'(busy), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
